// File: rtl/otter_io_pkg.sv
// Shared register map, control-bit positions and address decode for the IOBUS peripheral.
package otter_io_pkg;

  localparam logic [31:0] ADDR_SW        = 32'h1100_0000;
  localparam logic [31:0] ADDR_LED       = 32'h1100_0020;
  localparam logic [31:0] ADDR_TMR_LOAD  = 32'h1100_0040;
  localparam logic [31:0] ADDR_TMR_CTRL  = 32'h1100_0044;
  localparam logic [31:0] ADDR_TMR_COUNT = 32'h1100_0048;
  localparam logic [31:0] ADDR_IRQ_STAT  = 32'h1100_004C;
  localparam logic [31:0] ADDR_BTN_IE    = 32'h1100_0050;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_TIE    = 2;
  localparam int IRQ_BTN_OFS = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SW,
    SEL_LED,
    SEL_TMR_LOAD,
    SEL_TMR_CTRL,
    SEL_TMR_COUNT,
    SEL_IRQ_STAT,
    SEL_BTN_IE
  } reg_sel_e;

  // Word address in, register select out; the byte offset never takes part.
  function automatic reg_sel_e decode_addr(input logic [29:0] word_addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_addr == ADDR_SW[31:2])             sel = SEL_SW;
    else if (word_addr == ADDR_LED[31:2])       sel = SEL_LED;
    else if (word_addr == ADDR_TMR_LOAD[31:2])  sel = SEL_TMR_LOAD;
    else if (word_addr == ADDR_TMR_CTRL[31:2])  sel = SEL_TMR_CTRL;
    else if (word_addr == ADDR_TMR_COUNT[31:2]) sel = SEL_TMR_COUNT;
    else if (word_addr == ADDR_IRQ_STAT[31:2])  sel = SEL_IRQ_STAT;
    else if (word_addr == ADDR_BTN_IE[31:2])    sel = SEL_BTN_IE;
    return sel;
  endfunction

endpackage

// File: rtl/otter_iobus_periph_if.sv
// Core-to-peripheral IOBUS: address, write data and strobe out of the core, read data back.
interface otter_iobus_periph_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/io_timer.sv
// Countdown timer with prescaler and optional auto-reload; expire is a one-cycle pulse
// derived from registered state only.
module io_timer
  import otter_io_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_we,
  input  logic [31:0] load_data,
  input  logic        ctrl_we,
  input  logic [2:0]  ctrl_data,
  output logic [31:0] load_val,
  output logic [31:0] count,
  output logic [2:0]  ctrl,
  output logic        expire
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [31:0]   load_reg;
  logic [31:0]   count_reg;
  logic [PW-1:0] presc_reg;
  logic          en_reg;
  logic          auto_reg;
  logic          tie_reg;
  logic          tick;

  assign tick   = en_reg && (presc_reg == PRESC_LAST);
  assign expire = tick && (count_reg <= 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      load_reg  <= '0;
      count_reg <= '0;
      presc_reg <= '0;
      en_reg    <= 1'b0;
      auto_reg  <= 1'b0;
      tie_reg   <= 1'b0;
    end else begin
      if (load_we)
        load_reg <= load_data;

      if (tick || !en_reg)
        presc_reg <= '0;
      else
        presc_reg <= presc_reg + 1'b1;

      // A control write overrides whatever the tick would have done to COUNT/EN.
      if (ctrl_we) begin
        en_reg   <= ctrl_data[CTRL_EN];
        auto_reg <= ctrl_data[CTRL_AUTO];
        tie_reg  <= ctrl_data[CTRL_TIE];
        if (ctrl_data[CTRL_EN]) begin
          count_reg <= load_reg;
          presc_reg <= '0;
        end
      end else if (tick) begin
        if (count_reg <= 32'd1) begin
          if (auto_reg) begin
            count_reg <= load_reg;
          end else begin
            count_reg <= '0;
            en_reg    <= 1'b0;
          end
        end else begin
          count_reg <= count_reg - 32'd1;
        end
      end
    end
  end

  assign load_val = load_reg;
  assign count    = count_reg;
  assign ctrl     = {tie_reg, auto_reg, en_reg};

endmodule

// File: rtl/otter_iobus_periph.sv
// IOBUS device side: register decode, combinational read mux, LEDs, input synchronizers,
// interrupt pending bits and the level INTR output.
module otter_iobus_periph
  import otter_io_pkg::*;
#(
  parameter int SW_WIDTH  = 16,
  parameter int LED_WIDTH = 16,
  parameter int BTN_WIDTH = 4,
  parameter int PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 RESET,
  otter_iobus_periph_if.slave  bus,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  input  logic [BTN_WIDTH-1:0] BUTTONS,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 INTR
);

  reg_sel_e sel;
  logic     wr_led, wr_load, wr_ctrl, wr_irq, wr_ie;
  logic     unused_addr_lsb;

  assign sel     = decode_addr(bus.IOBUS_ADDR[31:2]);
  assign wr_led  = bus.IOBUS_WR && (sel == SEL_LED);
  assign wr_load = bus.IOBUS_WR && (sel == SEL_TMR_LOAD);
  assign wr_ctrl = bus.IOBUS_WR && (sel == SEL_TMR_CTRL);
  assign wr_irq  = bus.IOBUS_WR && (sel == SEL_IRQ_STAT);
  assign wr_ie   = bus.IOBUS_WR && (sel == SEL_BTN_IE);
  assign unused_addr_lsb = ^bus.IOBUS_ADDR[1:0];

  logic [SW_WIDTH-1:0]  sw_meta_reg, sw_sync_reg;
  logic [BTN_WIDTH-1:0] btn_meta_reg, btn_sync_reg, btn_prev_reg;
  logic [LED_WIDTH-1:0] led_reg;
  logic [BTN_WIDTH-1:0] btn_ie_reg;
  logic                 tmr_pend_reg, tmr_pend_next;
  logic [BTN_WIDTH-1:0] btn_pend_reg, btn_pend_next;

  logic [31:0] tmr_load;
  logic [31:0] tmr_count;
  logic [2:0]  tmr_ctrl;
  logic        tmr_expire;

  io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .rst       (RESET),
    .load_we   (wr_load),
    .load_data (bus.IOBUS_OUT),
    .ctrl_we   (wr_ctrl),
    .ctrl_data (bus.IOBUS_OUT[2:0]),
    .load_val  (tmr_load),
    .count     (tmr_count),
    .ctrl      (tmr_ctrl),
    .expire    (tmr_expire)
  );

  // Set beats a simultaneous write-1-to-clear on every pending bit.
  assign tmr_pend_next = tmr_expire | (tmr_pend_reg & ~(wr_irq & bus.IOBUS_OUT[0]));

  for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_btn_pend
    assign btn_pend_next[gi] = (btn_sync_reg[gi] & ~btn_prev_reg[gi] & btn_ie_reg[gi])
                             | (btn_pend_reg[gi] & ~(wr_irq & bus.IOBUS_OUT[IRQ_BTN_OFS + gi]));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
      btn_prev_reg <= '0;
      led_reg      <= '0;
      btn_ie_reg   <= '0;
      tmr_pend_reg <= 1'b0;
      btn_pend_reg <= '0;
    end else begin
      sw_meta_reg  <= SWITCHES;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= BUTTONS;
      btn_sync_reg <= btn_meta_reg;
      btn_prev_reg <= btn_sync_reg;
      if (wr_led)
        led_reg <= bus.IOBUS_OUT[LED_WIDTH-1:0];
      if (wr_ie)
        btn_ie_reg <= bus.IOBUS_OUT[BTN_WIDTH-1:0];
      tmr_pend_reg <= tmr_pend_next;
      btn_pend_reg <= btn_pend_next;
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_SW:        rdata = 32'(sw_sync_reg);
      SEL_LED:       rdata = 32'(led_reg);
      SEL_TMR_LOAD:  rdata = tmr_load;
      SEL_TMR_CTRL:  rdata = 32'(tmr_ctrl);
      SEL_TMR_COUNT: rdata = tmr_count;
      SEL_IRQ_STAT:  rdata = 32'(tmr_pend_reg) | (32'(btn_pend_reg) << IRQ_BTN_OFS);
      SEL_BTN_IE:    rdata = 32'(btn_ie_reg);
      default:       rdata = '0;
    endcase
  end

  assign bus.IOBUS_IN = rdata;
  assign LEDS         = led_reg;
  assign INTR         = (tmr_pend_reg & tmr_ctrl[CTRL_TIE]) | (|(btn_pend_reg & btn_ie_reg));

endmodule
